// File: rtl/a2d_arb.sv
// ---------------------------------------------------------------------------
// a2d_arb -- round-robin arbiter / sequencer for the shared SPI A2D converter
//
// Up to NUM_REQ requesters share one converter. The winner's channel is
// latched onto chnnl. After SETTLE_CYC cycles of mux settling, one strt_cnv
// pulse is issued. On cnv_cmplt the 12-bit result is captured and the winner
// receives a one-cycle done pulse. The last served index becomes the
// round-robin pointer, so the search for the next winner begins just after it.
//
// Optional feature macro: A2D_ARB_TIMEOUT_EN
//   defined   : CONV gives up after TIMEOUT_CYC cycles and pulses err[winner]
//   undefined : CONV waits forever for cnv_cmplt; err is tied low
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   SETTLE_CYC   mux settle cycles before strt_cnv (0 = none)
//   TIMEOUT_CYC  CONV cycles before timeout (macro build only)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   req        in   [NUM_REQ]   level request per requester
//   req_chnnl  in   [3*NUM_REQ] channel of requester i on [3i+2:3i]
//   gnt        out  [NUM_REQ]   one-hot grant, grant through done/err
//   done       out  [NUM_REQ]   one-cycle pulse when result is valid
//   err        out  [NUM_REQ]   one-cycle pulse on conversion timeout
//   result     out  [12]        last captured conversion result
//   busy       out              high whenever not IDLE
//   strt_cnv   out              one-cycle conversion start to A2D interface
//   chnnl      out  [3]         channel select to A2D interface
//   cnv_cmplt  in               conversion complete from A2D interface
//   res        in   [12]        conversion result, valid with cnv_cmplt
// ---------------------------------------------------------------------------
module a2d_arb #(
   parameter int NUM_REQ     = 3,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [3*NUM_REQ-1:0]   req_chnnl,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     err,
   output logic [11:0]            result,
   output logic                   busy,
   output logic                   strt_cnv,
   output logic [2:0]             chnnl,
   input  logic                   cnv_cmplt,
   input  logic [11:0]            res
);

   localparam int IDX_W = $clog2(NUM_REQ);
   // A zero-cycle settle never enters SETTLE; keep a 1-bit counter so the
   // declaration stays legal.
   localparam int SC_W  = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [SC_W-1:0]  SC_LAST = SC_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
   localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

`ifdef A2D_ARB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CONV
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  done_q, done_d;
   logic [11:0]         result_q, result_d;
   logic                strt_q, strt_d;
   logic [2:0]          chnnl_q, chnnl_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic [SC_W-1:0]     scnt_q, scnt_d;
   logic [IDX_W:0]      pick;

`ifdef A2D_ARB_TIMEOUT_EN
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [TO_W-1:0]     tcnt_q, tcnt_d;
`else
   logic                unused_to;
   assign unused_to = (TIMEOUT_CYC == 0);
`endif

   // Round-robin search starting one past the last served index.
   // Returns {found, index}.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   last);
      logic             found;
      logic [IDX_W-1:0] idx;
      int               cand;
      found = 1'b0;
      idx   = last;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = int'(last) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!found && r[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[IDX_W-1:0];
         end
      end
      return {found, idx};
   endfunction

   function automatic logic [2:0] chan_of(input logic [3*NUM_REQ-1:0] chv,
                                          input logic [IDX_W-1:0]     idx);
      logic [2:0] c;
      c = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (idx == IDX_W'(i)) begin
            c = chv[3*i +: 3];
         end
      end
      return c;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

   assign pick = rr_pick(req, ptr_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= 12'h000;
         strt_q   <= 1'b0;
         chnnl_q  <= 3'd0;
         ptr_q    <= PTR_RST;
         win_q    <= PTR_RST;
         scnt_q   <= '0;
`ifdef A2D_ARB_TIMEOUT_EN
         err_q    <= '0;
         tcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         strt_q   <= strt_d;
         chnnl_q  <= chnnl_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         scnt_q   <= scnt_d;
`ifdef A2D_ARB_TIMEOUT_EN
         err_q    <= err_d;
         tcnt_q   <= tcnt_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      result_d = result_q;
      strt_d   = 1'b0;
      chnnl_d  = chnnl_q;
      ptr_d    = ptr_q;
      win_d    = win_q;
      scnt_d   = '0;
`ifdef A2D_ARB_TIMEOUT_EN
      err_d    = '0;
      tcnt_d   = '0;
`endif

      case (state_q)
         S_IDLE: begin
            if (pick[IDX_W]) begin
               win_d   = pick[IDX_W-1:0];
               gnt_d   = onehot(pick[IDX_W-1:0]);
               chnnl_d = chan_of(req_chnnl, pick[IDX_W-1:0]);
               if (SETTLE_CYC == 0) begin
                  strt_d  = 1'b1;
                  state_d = S_CONV;
               end else begin
                  state_d = S_SETTLE;
               end
            end
         end

         S_SETTLE: begin
            scnt_d = scnt_q + SC_W'(1);
            if (scnt_q == SC_LAST) begin
               strt_d  = 1'b1;
               state_d = S_CONV;
            end
         end

         S_CONV: begin
            // strt_q is high only in the first CONV cycle; a completion in
            // that cycle cannot belong to the conversion just started.
            if (!strt_q && cnv_cmplt) begin
               result_d = res;
               done_d   = gnt_q;
               gnt_d    = '0;
               ptr_d    = win_q;
               state_d  = S_IDLE;
            end
`ifdef A2D_ARB_TIMEOUT_EN
            else if (tcnt_q == TO_LAST) begin
               err_d   = gnt_q;
               gnt_d   = '0;
               ptr_d   = win_q;
               state_d = S_IDLE;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
`endif
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign gnt      = gnt_q;
   assign done     = done_q;
   assign result   = result_q;
   assign strt_cnv = strt_q;
   assign chnnl    = chnnl_q;
   assign busy     = (state_q != S_IDLE);
`ifdef A2D_ARB_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = '0;
`endif

endmodule
